examine_jump: RTL and testbench

Front-panel EXAMINE sequencer for the Altair 8800 core, the read-side counterpart of the deposit path. On an EXAMINE request it forces a `JMP addr` (0xC3, low byte, high byte) onto the CPU data-in bus across three successive CPU read cycles, with `addr` taken from the address switches. It then releases the bus and captures the byte the CPU reads from the target address for the panel data LEDs. It sits between the panel switch debouncers and the CPU data-in multiplexer, alongside the deposit logic.

---
 rtl/panel_pkg.sv | 15 +
 rtl/examine_jump_if.sv | 10 +
 rtl/rd_edge.sv | 18 +
 rtl/examine_jump.sv | 108 ++++++++++
 tb/tb_examine_jump.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/panel_pkg.sv
// Shared front-panel definitions: sequencer states and the opcodes jammed onto the CPU bus.
package panel_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_CAP  = 3'd4
    } state_t;

    localparam logic [7:0] OP_JMP = 8'hC3;
    localparam logic [7:0] OP_NOP = 8'h00;

endpackage

// File: rtl/examine_jump_if.sv
// CPU data-in side of the panel: read strobe, memory data, and the jammed byte plus mux select.
interface examine_jump_if;
    logic       rd;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       examine_latch;

    modport master (output rd, data_in, input data_out, examine_latch);
    modport slave  (input rd, data_in, output data_out, examine_latch);
endinterface

// File: rtl/rd_edge.sv
// Registered strobe edge detector; rise/fall are valid in the cycle the strobe changes level.
module rd_edge (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b0;
        else       prev <= strobe;
    end

    assign rise = strobe & ~prev;
    assign fall = prev & ~strobe;
endmodule

// File: rtl/examine_jump.sv
// Front-panel EXAMINE sequencer: jams JMP addr onto the CPU bus, then captures the target byte.
//   state | meaning
//   IDLE  | bus released, led_data holds
//   ARM   | opcode on bus, waiting for opcode read to end
//   LO    | address low byte on bus
//   HI    | address high byte on bus
//   CAP   | bus released, sampling memory data for the LEDs
module examine_jump
    import panel_pkg::*;
#(
    parameter logic [7:0] JMP_OP = OP_JMP
) (
    input  logic             clk,
    input  logic             reset,
    examine_jump_if.slave    bus,
    input  logic             examine,
    input  logic [15:0]      addr_sw,
    output logic [7:0]       led_data,
    output logic             busy,
    output logic             done
);
    state_t      state, state_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        latch_q, latch_d;
    logic [7:0]  led_q, led_d;
    logic        done_q, done_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  rd_q, rd_q_d;
    logic        rd_fall;
    logic        rd_rise_unused;

    rd_edge u_rd_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (bus.rd),
        .rise   (rd_rise_unused),
        .fall   (rd_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            data_out_q <= OP_NOP;
            latch_q    <= 1'b0;
            led_q      <= 8'h00;
            done_q     <= 1'b0;
            addr_q     <= 16'h0000;
            rd_q       <= 8'h00;
        end else begin
            state      <= state_d;
            data_out_q <= data_out_d;
            latch_q    <= latch_d;
            led_q      <= led_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            rd_q       <= rd_q_d;
        end
    end

    always_comb begin
        state_d    = state;
        data_out_d = data_out_q;
        latch_d    = latch_q;
        led_d      = led_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        rd_q_d     = rd_q;

        // A held or re-asserted examine restarts the sequence and swallows any read edge.
        if (examine) begin
            state_d    = S_ARM;
            latch_d    = 1'b1;
            data_out_d = JMP_OP;
            addr_d     = addr_sw;
        end else begin
            case (state)
                S_ARM: if (rd_fall) begin
                    state_d    = S_LO;
                    data_out_d = addr_q[7:0];
                end
                S_LO: if (rd_fall) begin
                    state_d    = S_HI;
                    data_out_d = addr_q[15:8];
                end
                S_HI: if (rd_fall) begin
                    state_d    = S_CAP;
                    latch_d    = 1'b0;
                    data_out_d = OP_NOP;
                end
                S_CAP: begin
                    if (bus.rd) rd_q_d = bus.data_in;
                    if (rd_fall) begin
                        led_d   = rd_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.examine_latch = latch_q;
    assign led_data          = led_q;
    assign done              = done_q;
    assign busy              = (state != S_IDLE);
endmodule

// File: tb/tb_examine_jump.sv
// Directed bench for the EXAMINE sequencer: JMP jamming, capture, restart, reset, collision, held examine.
module tb_examine_jump;
    logic        clk = 1'b0;
    logic        reset;
    logic        examine;
    logic [15:0] addr_sw;
    logic [7:0]  led_data;
    logic        busy;
    logic        done;
    int          n_tests = 0;
    int          n_fail  = 0;

    examine_jump_if bus ();

    examine_jump dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .examine  (examine),
        .addr_sw  (addr_sw),
        .led_data (led_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Two cycles with rd high, then one cycle low; the fall is acted on at the third edge.
    task automatic read_cycle(input logic [7:0] d);
        bus.rd = 1'b1; bus.data_in = d;
        step();
        step();
        bus.rd = 1'b0; bus.data_in = 8'h5A;
        step();
    endtask

    task automatic start_examine(input logic [15:0] a);
        addr_sw = a; examine = 1'b1;
        step();
        examine = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; examine = 1'b0; addr_sw = 16'h0000;
        bus.rd = 1'b0; bus.data_in = 8'h00;
        step(); step();
        reset = 1'b0;
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_latch",    8'(bus.examine_latch), 8'h00);
        chk("rst_led",      led_data, 8'h00);
        chk("rst_done",     8'(done), 8'h00);
        chk("rst_busy",     8'(busy), 8'h00);

        // basic examine + capture
        start_examine(16'h1234);
        chk("arm_data",  bus.data_out, 8'hC3);
        chk("arm_latch", 8'(bus.examine_latch), 8'h01);
        chk("arm_busy",  8'(busy), 8'h01);
        bus.rd = 1'b1; step(); step();
        chk("op_window", bus.data_out, 8'hC3);
        bus.rd = 1'b0; step();
        chk("lo_data",  bus.data_out, 8'h34);
        chk("lo_latch", 8'(bus.examine_latch), 8'h01);
        read_cycle(8'h00);
        chk("hi_data",  bus.data_out, 8'h12);
        chk("hi_latch", 8'(bus.examine_latch), 8'h01);
        read_cycle(8'h00);
        chk("cap_latch", 8'(bus.examine_latch), 8'h00);
        chk("cap_data",  bus.data_out, 8'h00);
        bus.rd = 1'b1; bus.data_in = 8'hA5;
        step(); step();
        chk("cap_rd_latch", 8'(bus.examine_latch), 8'h00);
        chk("cap_no_done",  8'(done), 8'h00);
        bus.rd = 1'b0; bus.data_in = 8'hFF;
        step();
        chk("cap_led",  led_data, 8'hA5);
        chk("cap_done", 8'(done), 8'h01);
        chk("cap_busy", 8'(busy), 8'h00);
        step();
        chk("done_pulse", 8'(done), 8'h00);
        chk("led_hold",   led_data, 8'hA5);
        read_cycle(8'h77);
        chk("idle_ignore_rd", led_data, 8'hA5);
        chk("idle_busy",      8'(busy), 8'h00);

        // restart mid-sequence with a new address
        start_examine(16'h1234);
        read_cycle(8'h00);
        chk("rs_lo_old", bus.data_out, 8'h34);
        start_examine(16'hBEEF);
        chk("rs_arm", bus.data_out, 8'hC3);
        read_cycle(8'h00);
        chk("rs_lo", bus.data_out, 8'hEF);
        read_cycle(8'h00);
        chk("rs_hi", bus.data_out, 8'hBE);
        read_cycle(8'h00);
        read_cycle(8'h3C);
        chk("rs_led",  led_data, 8'h3C);
        chk("rs_done", 8'(done), 8'h01);

        // reset while in HI
        start_examine(16'h5678);
        read_cycle(8'h00);
        read_cycle(8'h00);
        chk("rst_mid_hi", bus.data_out, 8'h56);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_mid_latch", 8'(bus.examine_latch), 8'h00);
        chk("rst_mid_data",  bus.data_out, 8'h00);
        chk("rst_mid_led",   led_data, 8'h00);
        chk("rst_mid_busy",  8'(busy), 8'h00);
        read_cycle(8'h11); read_cycle(8'h22);
        chk("rst_after_data", bus.data_out, 8'h00);
        chk("rst_after_busy", 8'(busy), 8'h00);
        chk("rst_after_led",  led_data, 8'h00);

        // rd_fall coincident with examine
        start_examine(16'h0102);
        bus.rd = 1'b1; step(); step();
        bus.rd = 1'b0; addr_sw = 16'h0A0B; examine = 1'b1;
        step();
        examine = 1'b0;
        chk("col_arm", bus.data_out, 8'hC3);
        step();
        chk("col_no_count", bus.data_out, 8'hC3);
        read_cycle(8'h00);
        chk("col_lo", bus.data_out, 8'h0B);

        // held examine while rd toggles, released with rd high
        addr_sw = 16'h7788; examine = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rd = ~bus.rd;
            step();
            chk("held_arm", bus.data_out, 8'hC3);
        end
        bus.rd = 1'b1; step();
        examine = 1'b0; step();
        chk("held_release", bus.data_out, 8'hC3);
        bus.rd = 1'b0; step();
        chk("held_lo", bus.data_out, 8'h88);
        read_cycle(8'h00);
        chk("held_hi", bus.data_out, 8'h77);
        read_cycle(8'h00);
        read_cycle(8'h99);
        chk("held_led",  led_data, 8'h99);
        chk("held_done", 8'(done), 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
